// File: rtl/if_fetch_queue.sv
// Instruction fetch unit: PC sequencer over a one-cycle synchronous imem, feeding a prefetch FIFO.
// Optional IF_BYPASS_EN forwards a response straight to the outputs when the queue is empty.
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                IMEM_AW  = 10,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      stall,
  input  logic                      halt,
  input  logic                      interrupt,
  input  logic                      eret,
  input  logic [ADDR_W-1:0]         int_pc,
  input  logic                      redir_valid,
  input  logic [ADDR_W-1:0]         redir_pc,
  output logic                      imem_req,
  output logic [IMEM_AW-1:0]        imem_addr,
  input  logic [ADDR_W-1:0]         imem_rdata,
  output logic                      out_valid,
  output logic [ADDR_W-1:0]         pc_out,
  output logic [ADDR_W-1:0]         instruction,
  output logic                      halted,
  output logic [$clog2(QDEPTH):0]   q_count
);
  localparam int QAW = $clog2(QDEPTH);

  typedef enum logic {RUN, HALTED} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                inflight_q;
  logic [ADDR_W-1:0]   infl_pc_q;
  logic [ADDR_W-1:0]   qpc_q  [QDEPTH];
  logic [ADDR_W-1:0]   qins_q [QDEPTH];
  logic [QAW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [QAW:0]        count_q, count_d;

  logic trap, redirect, room, issue, rsp_ok, q_empty, byp, push, pop;

  assign trap     = interrupt | eret;
  assign redirect = trap | (redir_valid & (state_q == RUN));
  assign room     = (32'(count_q) + 32'(inflight_q)) < 32'(QDEPTH);
  // RST gates the strobe so nothing is requested while reset is held
  assign issue    = RST & (state_q == RUN) & ~redirect & room;
  assign rsp_ok   = inflight_q & ~redirect;
  assign q_empty  = (count_q == '0);
`ifdef IF_BYPASS_EN
  assign byp      = q_empty & ~stall & rsp_ok;
`else
  assign byp      = 1'b0;
`endif
  assign push     = rsp_ok & ~byp;
  assign pop      = ~q_empty & ~stall;

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_q[IMEM_AW+1:2];
  assign out_valid   = ~q_empty | byp;
  assign pc_out      = !q_empty ? qpc_q[rd_ptr_q]  : (byp ? infl_pc_q  : '0);
  assign instruction = !q_empty ? qins_q[rd_ptr_q] : (byp ? imem_rdata : '0);
  assign halted      = (state_q == HALTED);
  assign q_count     = count_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q + (QAW+1)'(push) - (QAW+1)'(pop);
    if (redirect) begin
      fetch_pc_d = trap ? int_pc : redir_pc;
      count_d    = '0;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
    case (state_q)
      RUN:     if (halt && !redirect) state_d = HALTED;
      HALTED:  if (trap) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      infl_pc_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) infl_pc_q <= fetch_pc_q;
      count_q    <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: count_q alone decides which slots are live
  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[wr_ptr_q]  <= infl_pc_q;
      qins_q[wr_ptr_q] <= imem_rdata;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed scenarios plus random traffic, every cycle compared against a queue-based reference model.
module tb_if_fetch_queue;
  localparam int AW  = 32;
  localparam int IAW = 10;
  localparam int QD  = 4;
`ifdef IF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, RST = 1'b0;
  logic stall = 0, halt = 0, interrupt = 0, eret = 0, redir_valid = 0;
  logic [AW-1:0] int_pc = '0, redir_pc = '0, imem_rdata = '0;
  logic imem_req, out_valid, halted;
  logic [IAW-1:0] imem_addr;
  logic [AW-1:0] pc_out, instruction;
  logic [2:0] q_count;
  int total = 0, bad = 0;

  logic [31:0] m_pc, m_ipc;
  bit m_inf, m_halt;
  logic [31:0] mq_pc[$];
  logic [31:0] mq_ins[$];

  always #5 clk = ~clk;

  if_fetch_queue #(.ADDR_W(AW), .IMEM_AW(IAW), .QDEPTH(QD), .RESET_PC('0)) dut (
    .clk(clk), .RST(RST), .stall(stall), .halt(halt), .interrupt(interrupt),
    .eret(eret), .int_pc(int_pc), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .pc_out(pc_out), .instruction(instruction),
    .halted(halted), .q_count(q_count));

  // memory word n holds n*0x11, one-cycle read latency
  always @(posedge clk) if (imem_req) imem_rdata <= 32'(imem_addr) * 32'h11;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'(pc[IAW+1:2]) * 32'h11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_pc = '0; m_ipc = '0; m_inf = 0; m_halt = 0;
    mq_pc.delete(); mq_ins.delete();
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_vld"}, out_valid, 0);
    chk({tag, "_pc"}, pc_out, 0);
    chk({tag, "_ins"}, instruction, 0);
    chk({tag, "_cnt"}, q_count, 0);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_hlt"}, halted, 0);
  endtask

  // one clock: compare outputs to the model, then advance the model across the edge
  task automatic step();
    bit trap, rd, req, rsp, byp, e_v;
    logic [31:0] e_pc, e_ins;
    #1;
    trap = interrupt | eret;
    rd   = trap | (redir_valid & !m_halt);
    req  = !m_halt && !rd && (mq_pc.size() + int'(m_inf) < QD);
    rsp  = m_inf && !rd;
    byp  = BYP && mq_pc.size() == 0 && !stall && rsp;
    if (mq_pc.size() != 0) begin e_v = 1; e_pc = mq_pc[0]; e_ins = mq_ins[0]; end
    else if (byp) begin e_v = 1; e_pc = m_ipc; e_ins = instr_of(m_ipc); end
    else begin e_v = 0; e_pc = 0; e_ins = 0; end
    chk("m_vld", out_valid, e_v);
    chk("m_pc", pc_out, e_pc);
    chk("m_ins", instruction, e_ins);
    chk("m_cnt", q_count, mq_pc.size());
    chk("m_req", imem_req, req);
    chk("m_addr", imem_addr, m_pc[IAW+1:2]);
    chk("m_hlt", halted, m_halt);
    @(posedge clk);
    if (mq_pc.size() != 0 && !stall) begin void'(mq_pc.pop_front()); void'(mq_ins.pop_front()); end
    if (rsp && !byp) begin mq_pc.push_back(m_ipc); mq_ins.push_back(instr_of(m_ipc)); end
    if (rd) begin mq_pc.delete(); mq_ins.delete(); end
    m_ipc = m_pc;
    m_inf = req;
    if (rd) m_pc = trap ? int_pc : redir_pc;
    else if (req) m_pc = m_pc + 4;
    if (trap) m_halt = 0;
    else if (halt && !rd) m_halt = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    RST = 0;
    #1 rst_chk("rst");
    mreset();
    @(posedge clk);
    @(negedge clk);
    RST = 1;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    bit found = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (out_valid === 1'b1) begin found = 1; break; end
      step();
    end
    chk({tag, "_found"}, found, 1);
    chk({tag, "_pc"}, pc_out, exp_pc);
  endtask

  initial begin
    mreset();
    #3 rst_chk("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1;

    // startup latency and first two words
    step();
    #1 chk("c1_vld", out_valid, BYP);
    if (!BYP) step();
    #1 chk("first_vld", out_valid, 1);
    chk("first_pc", pc_out, 32'h0);
    chk("first_ins", instruction, 32'h0);
    step();
    #1 chk("second_pc", pc_out, 32'h4);
    chk("second_ins", instruction, 32'h11);
    step();

    // saturation under stall, then ordered drain
    stall = 1;
    do_reset();
    repeat (10) step();
    #1 chk("full_cnt", q_count, 4);
    chk("full_req", imem_req, 0);
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_pc", pc_out, 32'(4 * i));
      step();
    end

    // branch redirect with 3 queued and 1 in flight
    stall = 1;
    do_reset();
    repeat (4) step();
    #1 chk("pre_redir_cnt", q_count, 3);
    redir_valid = 1; redir_pc = 32'h100;
    step();
    redir_valid = 0; stall = 0;
    #1 chk("flush_cnt", q_count, 0);
    wait_valid("redir", 32'h100);
    step();

    // interrupt beats branch redirect
    interrupt = 1; redir_valid = 1; int_pc = 32'h80; redir_pc = 32'h200;
    step();
    interrupt = 0; redir_valid = 0;
    #1 chk("int_addr", imem_addr, 10'h20);
    wait_valid("int", 32'h80);
    step();

    // halt, drain, resume via eret
    halt = 1;
    step();
    halt = 0;
    #1 chk("halted", halted, 1);
    repeat (6) step();
    #1 chk("halt_cnt", q_count, 0);
    chk("halt_req", imem_req, 0);
    eret = 1; int_pc = 32'h40;
    step();
    eret = 0;
    #1 chk("resume_hlt", halted, 0);
    chk("resume_addr", imem_addr, 10'h10);
    wait_valid("eret", 32'h40);
    step();

    // asynchronous reset mid-stream
    repeat (3) step();
    #2 RST = 0;
    #1 rst_chk("async");
    mreset();
    @(posedge clk);
    @(negedge clk);
    RST = 1;
    #1 chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
    step();

    // random traffic
    repeat (1500) begin
      stall       = ($urandom_range(0, 99) < 30);
      halt        = ($urandom_range(0, 99) < 3);
      interrupt   = ($urandom_range(0, 99) < 2);
      eret        = ($urandom_range(0, 99) < 2);
      redir_valid = ($urandom_range(0, 99) < 5);
      int_pc      = $urandom_range(0, 1) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      redir_pc    = $urandom & 32'hFFFF_FFFC;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
